// File: rtl/video_rx_pkg.sv
// Shared types for the parallel-video to Avalon-ST receiver: FSM states, FIFO beat and 720p defaults.
package video_rx_pkg;

    localparam int PIXEL_W            = 24;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_FIFO_DEPTH = 64;
    localparam int H_ACTIVE_720P      = 1280;
    localparam int V_ACTIVE_720P      = 720;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        FRAME_IDLE,
        ACTIVE,
        DROP
    } state_t;

    typedef struct packed {
        logic [PIXEL_W-1:0] data;
        logic               sop;
        logic               eop;
        logic               err;
    } beat_t;

    function automatic logic [PIXEL_W-1:0] pack_rgb(input logic [7:0] r,
                                                    input logic [7:0] g,
                                                    input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/hdmi_rx_avst_if.sv
// Video input bus plus Avalon-ST source bundle; master is the receiver, slave is its environment.
interface hdmi_rx_avst_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  vid_de_i;
    logic                  vid_hsync_i;
    logic                  vid_vsync_i;
    logic [7:0]            vid_r_i;
    logic [7:0]            vid_g_i;
    logic [7:0]            vid_b_i;
    logic                  aso_src_valid_o;
    logic                  aso_src_ready_i;
    logic [DATA_WIDTH-1:0] aso_src_data_o;
    logic                  aso_src_startofpacket_o;
    logic                  aso_src_endofpacket_o;
    logic                  aso_src_empty_o;
    logic                  aso_src_error_o;
    logic                  aso_src_channel_o;

    modport master (
        input  vid_de_i, vid_hsync_i, vid_vsync_i, vid_r_i, vid_g_i, vid_b_i,
        input  aso_src_ready_i,
        output aso_src_valid_o, aso_src_data_o, aso_src_startofpacket_o,
        output aso_src_endofpacket_o, aso_src_empty_o, aso_src_error_o, aso_src_channel_o
    );

    modport slave (
        output vid_de_i, vid_hsync_i, vid_vsync_i, vid_r_i, vid_g_i, vid_b_i,
        output aso_src_ready_i,
        input  aso_src_valid_o, aso_src_data_o, aso_src_startofpacket_o,
        input  aso_src_endofpacket_o, aso_src_empty_o, aso_src_error_o, aso_src_channel_o
    );

endinterface

// File: rtl/video_rx_fifo.sv
// Single-clock show-ahead FIFO of beats; the head entry is visible whenever empty is low.
module video_rx_fifo
    import video_rx_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  beat_t                    wr_beat,
    input  logic                     rd_en,
    output beat_t                    rd_beat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    beat_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign rd_beat = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_beat;
    end

endmodule

// File: rtl/hdmi_rx_avst.sv
// Frames DE/HSYNC/VSYNC video into one Avalon-ST packet per frame with geometry checking.
// Optional timing measurement outputs are enabled by defining HDMI_RX_TIMING_MEAS_EN.
module hdmi_rx_avst
    import video_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int H_ACTIVE   = H_ACTIVE_720P,
    parameter int V_ACTIVE   = V_ACTIVE_720P,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    hdmi_rx_avst_if.master     bus,
    output logic               sts_err_sticky_o
`ifdef HDMI_RX_TIMING_MEAS_EN
    ,
    output logic [12:0]        meas_hactive_o,
    output logic [12:0]        meas_htotal_o,
    output logic [12:0]        meas_vactive_o
`endif
);

    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int CW        = $clog2(FRAME_PIX);
    localparam int LW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIX - 1);

    logic                de_q;
    logic                vs_q;
    logic                vs_d;
    logic [PIXEL_W-1:0]  rgb_q;
    logic                vsync_start;

    state_t              state;
    logic                armed;
    logic [CW-1:0]       pix_cnt;
    logic                wr_en_q;
    beat_t               wr_beat_q;

    beat_t               head;
    logic                fifo_empty;
    logic [LW-1:0]       fifo_level;
    logic [LW-1:0]       level_eff;
    logic                room;
    logic                valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q  <= 1'b0;
            vs_q  <= 1'b0;
            vs_d  <= 1'b0;
            rgb_q <= '0;
        end else begin
            de_q  <= bus.vid_de_i;
            vs_q  <= bus.vid_vsync_i;
            vs_d  <= vs_q;
            rgb_q <= pack_rgb(bus.vid_r_i, bus.vid_g_i, bus.vid_b_i);
        end
    end

    assign vsync_start = vs_d & ~vs_q;

    // A write still in the pipeline counts against the FIFO; the last slot is kept for a flush beat.
    assign level_eff = fifo_level + LW'(wr_en_q);
    assign room      = (level_eff < LW'(FIFO_DEPTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= SYNC_WAIT;
            armed            <= 1'b0;
            pix_cnt          <= '0;
            wr_en_q          <= 1'b0;
            wr_beat_q        <= '0;
            sts_err_sticky_o <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                SYNC_WAIT: begin
                    if (vsync_start) begin
                        armed <= 1'b1;
                        state <= FRAME_IDLE;
                    end
                end
                FRAME_IDLE: begin
                    if (vsync_start) begin
                        armed <= 1'b1;
                    end else if (de_q) begin
                        if (armed && room) begin
                            wr_en_q   <= 1'b1;
                            wr_beat_q <= '{data: rgb_q, sop: 1'b1, eop: 1'b0, err: 1'b0};
                            pix_cnt   <= CW'(1);
                            armed     <= 1'b0;
                            state     <= ACTIVE;
                        end else begin
                            // Pixels of an over-long frame, or a frame with no buffer space, are dropped whole.
                            armed            <= 1'b0;
                            sts_err_sticky_o <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (vsync_start) begin
                        wr_en_q          <= 1'b1;
                        wr_beat_q        <= '{data: '0, sop: 1'b0, eop: 1'b1, err: 1'b1};
                        sts_err_sticky_o <= 1'b1;
                        pix_cnt          <= '0;
                        armed            <= 1'b1;
                        state            <= FRAME_IDLE;
                    end else if (de_q) begin
                        if (!room) begin
                            sts_err_sticky_o <= 1'b1;
                            pix_cnt          <= '0;
                            state            <= DROP;
                        end else if (pix_cnt == LAST_PIX) begin
                            wr_en_q   <= 1'b1;
                            wr_beat_q <= '{data: rgb_q, sop: 1'b0, eop: 1'b1, err: 1'b0};
                            pix_cnt   <= '0;
                            state     <= FRAME_IDLE;
                        end else begin
                            wr_en_q   <= 1'b1;
                            wr_beat_q <= '{data: rgb_q, sop: 1'b0, eop: 1'b0, err: 1'b0};
                            pix_cnt   <= pix_cnt + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (vsync_start) begin
                        wr_en_q   <= 1'b1;
                        wr_beat_q <= '{data: '0, sop: 1'b0, eop: 1'b1, err: 1'b1};
                        armed     <= 1'b1;
                        state     <= FRAME_IDLE;
                    end
                end
                default: state <= SYNC_WAIT;
            endcase
        end
    end

    video_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en_q),
        .wr_beat (wr_beat_q),
        .rd_en   (valid & bus.aso_src_ready_i),
        .rd_beat (head),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Head fields are gated so the bus reads all-zero whenever no beat is offered.
    assign valid                       = ~fifo_empty;
    assign bus.aso_src_valid_o         = valid;
    assign bus.aso_src_data_o          = valid ? DATA_WIDTH'(head.data) : '0;
    assign bus.aso_src_startofpacket_o = valid & head.sop;
    assign bus.aso_src_endofpacket_o   = valid & head.eop;
    assign bus.aso_src_error_o         = valid & head.eop & head.err;
    assign bus.aso_src_empty_o         = 1'b0;
    assign bus.aso_src_channel_o       = 1'b0;

`ifdef HDMI_RX_TIMING_MEAS_EN
    logic        hs_q;
    logic        hs_d;
    logic        de_d;
    logic [12:0] hact_cnt;
    logic [12:0] htot_cnt;
    logic [12:0] vline_cnt;
    logic        line_end;

    assign line_end = de_d & ~de_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q           <= 1'b0;
            hs_d           <= 1'b0;
            de_d           <= 1'b0;
            hact_cnt       <= '0;
            htot_cnt       <= '0;
            vline_cnt      <= '0;
            meas_hactive_o <= '0;
            meas_htotal_o  <= '0;
            meas_vactive_o <= '0;
        end else begin
            hs_q <= bus.vid_hsync_i;
            hs_d <= hs_q;
            de_d <= de_q;
            if (de_q) begin
                hact_cnt <= hact_cnt + 1'b1;
            end else if (de_d) begin
                meas_hactive_o <= hact_cnt;
                hact_cnt       <= '0;
            end
            if (hs_d && !hs_q) begin
                meas_htotal_o <= htot_cnt + 1'b1;
                htot_cnt      <= '0;
            end else begin
                htot_cnt <= htot_cnt + 1'b1;
            end
            if (vsync_start) begin
                meas_vactive_o <= vline_cnt + 13'(line_end);
                vline_cnt      <= '0;
            end else if (line_end) begin
                vline_cnt <= vline_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_rx_avst.sv
// Self-checking bench: frame scenarios from a vector table, scoreboard queue of expected beats.
module tb_hdmi_rx_avst;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic          err;
    } exp_beat_t;

    typedef struct {
        int lines;
        int mode;
        int exp_pix;
        bit exp_flush;
        bit exp_sticky;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic sticky;
`ifdef HDMI_RX_TIMING_MEAS_EN
    logic [12:0] meas_h;
    logic [12:0] meas_t;
    logic [12:0] meas_v;
`endif

    hdmi_rx_avst_if #(.DATA_WIDTH(DW)) bus ();

    hdmi_rx_avst #(
        .DATA_WIDTH (DW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .sts_err_sticky_o (sticky)
`ifdef HDMI_RX_TIMING_MEAS_EN
        ,
        .meas_hactive_o   (meas_h),
        .meas_htotal_o    (meas_t),
        .meas_vactive_o   (meas_v)
`endif
    );

    always #5 clk = ~clk;

    exp_beat_t exp_q[$];
    int  n_checks   = 0;
    int  n_pass     = 0;
    int  beat_cnt   = 0;
    int  ready_mode = 0;
    int  stored_lim = 0;
    int  pix_idx    = 0;
    int  frame_id   = 0;
    bit  flush_exp  = 1'b0;
    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready pattern: 0 = always ready, 1 = random (75%), 2 = stalled.
    initial begin
        bus.aso_src_ready_i = 1'b1;
        forever begin
            tick();
            case (ready_mode)
                0:       bus.aso_src_ready_i = 1'b1;
                1:       bus.aso_src_ready_i = ($urandom_range(0, 3) != 0);
                default: bus.aso_src_ready_i = 1'b0;
            endcase
        end
    end

    initial begin
        logic      stalled;
        exp_beat_t held;
        exp_beat_t act;
        exp_beat_t e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                act = {bus.aso_src_data_o, bus.aso_src_startofpacket_o,
                       bus.aso_src_endofpacket_o, bus.aso_src_error_o};
                if (stalled)
                    checkOutput("stall_hold", {bus.aso_src_valid_o, act}, {1'b1, held});
                if (bus.aso_src_valid_o && bus.aso_src_ready_i) begin
                    beat_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected_beat: got %0h, expected no beat at %0t", act, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", act, e);
                    end
                    stalled = 1'b0;
                end else if (bus.aso_src_valid_o) begin
                    stalled = 1'b1;
                    held    = act;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Drives active lines; pixels below stored_lim are pushed to the scoreboard as they are sent.
    task automatic applyStimulus(input int lines);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        for (int l = 0; l < lines; l++) begin
            bus.vid_hsync_i = 1'b0;
            repeat (2) tick();
            bus.vid_hsync_i = 1'b1;
            repeat (4) tick();
            for (int p = 0; p < H; p++) begin
                r = 8'(frame_id * 16 + l);
                g = 8'(p);
                b = 8'($urandom_range(0, 255));
                bus.vid_de_i = 1'b1;
                bus.vid_r_i  = r;
                bus.vid_g_i  = g;
                bus.vid_b_i  = b;
                if (pix_idx < stored_lim)
                    exp_q.push_back({8'h00, r, g, b, (pix_idx == 0),
                                     (pix_idx == stored_lim - 1) && !flush_exp, 1'b0});
                pix_idx++;
                tick();
            end
            bus.vid_de_i = 1'b0;
            repeat (10) tick();
        end
    endtask

    task automatic sendVsync();
        if (flush_exp)
            exp_q.push_back({32'h0, 1'b0, 1'b1, 1'b1});
        flush_exp = 1'b0;
        bus.vid_vsync_i = 1'b0;
        repeat (3) tick();
        bus.vid_vsync_i = 1'b1;
        repeat (3) tick();
    endtask

    task automatic waitDrain();
        int cycles;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < 3000) begin
            @(posedge clk);
            cycles++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{lines: 4, mode: 0, exp_pix: 32, exp_flush: 1'b0, exp_sticky: 1'b0};
        vecs[1] = '{lines: 4, mode: 1, exp_pix: 32, exp_flush: 1'b0, exp_sticky: 1'b0};
        vecs[2] = '{lines: 3, mode: 0, exp_pix: 24, exp_flush: 1'b1, exp_sticky: 1'b1};
        vecs[3] = '{lines: 4, mode: 2, exp_pix: 15, exp_flush: 1'b1, exp_sticky: 1'b1};
        vecs[4] = '{lines: 4, mode: 0, exp_pix: 32, exp_flush: 1'b0, exp_sticky: 1'b1};
        vecs[5] = '{lines: 5, mode: 0, exp_pix: 32, exp_flush: 1'b0, exp_sticky: 1'b1};
        vecs[6] = '{lines: 4, mode: 1, exp_pix: 32, exp_flush: 1'b0, exp_sticky: 1'b1};

        reset           = 1'b1;
        bus.vid_de_i    = 1'b0;
        bus.vid_hsync_i = 1'b1;
        bus.vid_vsync_i = 1'b1;
        bus.vid_r_i     = '0;
        bus.vid_g_i     = '0;
        bus.vid_b_i     = '0;
        repeat (4) tick();
        @(negedge clk);
        checkOutput("reset_valid", bus.aso_src_valid_o, 0);
        checkOutput("reset_data", bus.aso_src_data_o, 0);
        checkOutput("reset_sop_eop_err", {bus.aso_src_startofpacket_o, bus.aso_src_endofpacket_o,
                                          bus.aso_src_error_o}, 0);
        checkOutput("reset_empty_channel", {bus.aso_src_empty_o, bus.aso_src_channel_o}, 0);
        checkOutput("reset_sticky", sticky, 0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        sendVsync();

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d: %0d lines, ready mode %0d", i, vecs[i].lines, vecs[i].mode);
            beat_cnt   = 0;
            ready_mode = vecs[i].mode;
            stored_lim = vecs[i].exp_pix;
            flush_exp  = vecs[i].exp_flush;
            pix_idx    = 0;
            frame_id   = i;
            applyStimulus(vecs[i].lines);
            sendVsync();
            repeat (6) tick();
            ready_mode = 0;
            waitDrain();
            checkOutput("beat_count", beat_cnt, vecs[i].exp_pix + int'(vecs[i].exp_flush));
            checkOutput("sticky", sticky, vecs[i].exp_sticky);
        end

        $display("[TB] reset mid-frame");
        ready_mode = 2;
        stored_lim = 0;
        flush_exp  = 1'b0;
        pix_idx    = 0;
        frame_id   = 9;
        applyStimulus(2);
        checkOutput("pre_reset_valid", bus.aso_src_valid_o, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_valid", bus.aso_src_valid_o, 0);
        checkOutput("midreset_sop_data", {bus.aso_src_startofpacket_o, bus.aso_src_data_o}, 0);
        checkOutput("midreset_sticky", sticky, 0);
        tick();
        reset      = 1'b0;
        ready_mode = 0;
        exp_q.delete();
        beat_cnt   = 0;
        pix_idx    = 0;
        applyStimulus(2);
        repeat (10) tick();
        checkOutput("sync_wait_discard", beat_cnt, 0);
        checkOutput("sync_wait_valid", bus.aso_src_valid_o, 0);
        sendVsync();
        stored_lim = 32;
        pix_idx    = 0;
        frame_id   = 10;
        applyStimulus(4);
        sendVsync();
        waitDrain();
        checkOutput("post_reset_beat_count", beat_cnt, 32);
        checkOutput("post_reset_sticky", sticky, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
